dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// Holds the responder state encoding and the address error check.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 32;
  localparam int BE_W   = WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned, or word index beyond the idx_w-bit storage range.
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int idx_w);
    logic [ADDR_W-1:0] hi;
    hi = addr >> (idx_w + 2);
    return (|addr[1:0]) || (|hi);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage built from one byte-wide array per lane: synchronous
// per-lane write, combinational word read at the same address.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [BE_W-1:0]   we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (we[gi]) begin
          lane_mem[addr] <= wdata[gi*8 +: 8];
        end
      end

      assign rdata[gi*8 +: 8] = lane_mem[addr];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: accepts one request in IDLE, answers after
// LATENCY cycles. Optional byte strobes via macro DMEM_BYTE_STROBE_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk_i,
  input  logic              rst_n,        // active-high despite the name
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [WORD_W-1:0] req_wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [BE_W-1:0]   req_be_i,
`endif
  output logic              req_ready_o,
  output logic              resp_valid_o,
  output logic [WORD_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                ready_reg;
  logic                write_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [WORD_W-1:0]   wdata_reg;
  logic [WORD_W-1:0]   rdata_reg;
  logic                err_reg;

  logic                accept;
  logic                enter_resp;
  logic                cur_write;
  logic [ADDR_W-1:0]   cur_addr;
  logic [WORD_W-1:0]   cur_wdata;
  logic [BE_W-1:0]     cur_be;
  logic                cur_err;
  logic [BE_W-1:0]     mem_we;
  logic [WORD_W-1:0]   mem_rdata;

  assign accept     = req_valid_i && ready_reg;
  assign enter_resp = (state_next == RESP);

  // With LATENCY==1 the response edge is the acceptance edge, so the live
  // inputs are used there; otherwise the captured request is used.
  assign cur_write = (state_reg == IDLE) ? req_write_i : write_reg;
  assign cur_addr  = (state_reg == IDLE) ? req_addr_i  : addr_reg;
  assign cur_wdata = (state_reg == IDLE) ? req_wdata_i : wdata_reg;
  assign cur_err   = addr_err(cur_addr, IDX_W);

`ifdef DMEM_BYTE_STROBE_EN
  logic [BE_W-1:0] be_reg;
  assign cur_be = (state_reg == IDLE) ? req_be_i : be_reg;

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      be_reg <= '0;
    end else if (accept) begin
      be_reg <= req_be_i;
    end
  end
`else
  assign cur_be = {BE_W{1'b1}};
`endif

  assign mem_we = (enter_resp && cur_write && !cur_err) ? cur_be : '0;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk_i),
    .we    (mem_we),
    .addr  (cur_addr[2 +: IDX_W]),
    .wdata (cur_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      write_reg <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Registered so ready stays low through reset and rises one edge later.
      ready_reg <= (state_next == IDLE);
      if (accept) begin
        write_reg <= req_write_i;
        addr_reg  <= req_addr_i;
        wdata_reg <= req_wdata_i;
      end
      rdata_reg <= (enter_resp && !cur_write && !cur_err) ? mem_rdata : '0;
      err_reg   <= enter_resp && cur_err;
    end
  end

  assign req_ready_o  = ready_reg;
  assign resp_valid_o = (state_reg == RESP);
  assign resp_rdata_o = rdata_reg;
  assign resp_err_o   = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main
// traffic and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        l1_valid, l1_write;
  logic [31:0] l1_addr, l1_wdata;
  logic        l1_ready, l1_resp_valid, l1_resp_err;
  logic [31:0] l1_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
    .clk_i        (clk),
    .rst_n        (rst),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be_i     (req_be),
`endif
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .resp_err_o   (resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
    .clk_i        (clk),
    .rst_n        (rst),
    .req_valid_i  (l1_valid),
    .req_write_i  (l1_write),
    .req_addr_i   (l1_addr),
    .req_wdata_i  (l1_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be_i     (4'hF),
`endif
    .req_ready_o  (l1_ready),
    .resp_valid_o (l1_resp_valid),
    .resp_rdata_o (l1_resp_rdata),
    .resp_err_o   (l1_resp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; optionally scrambles the request
  // inputs while the request is in flight.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit toggle,
                        output logic [31:0] rdata, output logic err);
    int waitc;
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_wait", 32'(waitc < 20), 32'd1);
    @(posedge clk);
    #1;
    if (toggle) begin
      req_write = ~wr;
      req_addr  = addr + 32'd4;
      req_wdata = ~wdata;
      req_be    = ~be;
    end else begin
      req_valid = 1'b0;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    req_valid = 1'b0;
    req_write = 1'b0;
    check("latency", 32'(lat), 32'd2);
    check("ready_in_resp", 32'(req_ready), 32'd0);
    rdata = resp_rdata;
    err   = resp_err;
    @(negedge clk);
    check("pulse_width", 32'(resp_valid), 32'd0);
    $display("txn %s addr=0x%08h wdata=0x%08h be=%b -> rdata=0x%08h err=%0d lat=%0d",
             wr ? "ST" : "LD", addr, wdata, be, rdata, err, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;
  logic [3:0]  exp_ready [6] = '{1, 0, 1, 0, 1, 0};
  logic [3:0]  exp_valid [6] = '{0, 1, 0, 1, 0, 1};
  logic [31:0] exp_rdata [6] = '{0, 0, 0, 32'h12345678, 0, 32'h12345678};

  initial begin
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 4'hF;
    l1_valid = 0; l1_write = 0; l1_addr = 0; l1_wdata = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_ready_l1", 32'(l1_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(req_ready), 32'd1);
    check("ready_after_edge_l1", 32'(l1_ready), 32'd1);

    // Basic store / load round trip
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    check("st10_err", 32'(er), 32'd0);
    check("st10_rdata", rd, 32'd0);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", 32'(er), 32'd0);

    // Error cases: misaligned and out of range, loads and stores
    do_req(1'b1, 32'h4, 32'h0A0B0C0D, 4'hF, 0, rd, er);
    do_req(1'b0, 32'h13, 32'h0, 4'hF, 0, rd, er);
    check("ld13_err", 32'(er), 32'd1);
    check("ld13_rdata", rd, 32'd0);
    do_req(1'b0, 32'h400, 32'h0, 4'hF, 0, rd, er);
    check("ld400_err", 32'(er), 32'd1);
    check("ld400_rdata", rd, 32'd0);
    do_req(1'b1, 32'h11, 32'h99999999, 4'hF, 0, rd, er);
    check("st11_err", 32'(er), 32'd1);
    do_req(1'b1, 32'h404, 32'h77777777, 4'hF, 0, rd, er);
    check("st404_err", 32'(er), 32'd1);
    do_req(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    check("ld10_after_err", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h4, 32'h0, 4'hF, 0, rd, er);
    check("ld4_after_err", rd, 32'h0A0B0C0D);

    // Inputs scrambled during WAIT must not affect the captured request
    do_req(1'b1, 32'h34, 32'h01020304, 4'hF, 0, rd, er);
    do_req(1'b1, 32'h30, 32'h55667788, 4'hF, 1, rd, er);
    check("toggle_st_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
    check("toggle_ld30", rd, 32'h55667788);
    do_req(1'b0, 32'h34, 32'h0, 4'hF, 0, rd, er);
    check("toggle_ld34", rd, 32'h01020304);

    // LATENCY=1 instance: valid held high, one store then loads
    l1_valid = 1'b1; l1_write = 1'b1; l1_addr = 32'h20; l1_wdata = 32'h12345678;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("l1_ready_%0d", i), 32'(l1_ready), 32'(exp_ready[i]));
      check($sformatf("l1_valid_%0d", i), 32'(l1_resp_valid), 32'(exp_valid[i]));
      check($sformatf("l1_rdata_%0d", i), l1_resp_rdata, exp_rdata[i]);
      $display("txn L1 cycle %0d ready=%0d valid=%0d rdata=0x%08h",
               i, l1_ready, l1_resp_valid, l1_resp_rdata);
      if (i == 1) l1_write = 1'b0;
      @(negedge clk);
    end
    l1_valid = 1'b0;

    // Reset pulsed while a store sits in WAIT
    do_req(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 0, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h0BADBEEF;
    check("abort_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("abort_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("abort_ready_high", 32'(req_ready), 32'd1);
    check("abort_no_resp_after", 32'(resp_valid), 32'd0);
    $display("txn ST addr=0x00000040 wdata=0x0badbeef aborted by reset");
    do_req(1'b0, 32'h40, 32'h0, 4'hF, 0, rd, er);
    check("abort_ld40", rd, 32'hCAFEF00D);

`ifdef DMEM_BYTE_STROBE_EN
    do_req(1'b1, 32'h50, 32'h11223344, 4'hF, 0, rd, er);
    do_req(1'b1, 32'h50, 32'hAABBCCDD, 4'b0101, 0, rd, er);
    check("be_st_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h50, 32'h0, 4'hF, 0, rd, er);
    check("be_ld50", rd, 32'h11BB33DD);
    do_req(1'b1, 32'h50, 32'hFFFFFFFF, 4'b0000, 0, rd, er);
    check("be0_err", 32'(er), 32'd0);
    do_req(1'b0, 32'h50, 32'h0, 4'hF, 0, rd, er);
    check("be0_ld50", rd, 32'h11BB33DD);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
